// File: rtl/cnt_seq_ctrl_pkg.sv
// cnt_seq_ctrl_pkg: shared state encoding and default widths for the counter sequencer
package cnt_seq_ctrl_pkg;
  localparam int CNT_W_DEF = 4;
  localparam int PER_W_DEF = 8;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    LOAD  = 3'd2,
    RUN   = 3'd3,
    DONE  = 3'd4
  } state_e;
endpackage

// File: rtl/cnt_seq_ctrl.sv
// cnt_seq_ctrl: sequences clear/load/incr of an up-counter and counts qualified carry wraps
module cnt_seq_ctrl
  import cnt_seq_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int PER_W = PER_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_load_val,
  input  logic [PER_W-1:0] cmd_periods,
  input  logic             cmd_abort,
  input  logic             tick_en,
  output logic             cnt_clear,
  output logic             cnt_load,
  output logic             cnt_incr,
  output logic [CNT_W-1:0] cnt_d,
  input  logic             cnt_c,
  output logic             busy,
  output logic [PER_W-1:0] periods_left,
  output logic             done,
  output logic             aborted
);
  state_e           state_q, state_d;
  logic [PER_W-1:0] periods_left_q, periods_left_d;
  logic [CNT_W-1:0] load_val_q, load_val_d;
  logic             incr_q, aborted_q, aborted_d;
  logic             act_abort, wrap;
  always_comb begin
    act_abort      = cmd_abort && state_q != IDLE;
    // carry is only meaningful right after an increment; it is stale across clear/load
    wrap           = cnt_c && incr_q && state_q == RUN;
    state_d        = state_q;
    periods_left_d = periods_left_q;
    load_val_d     = load_val_q;
    cnt_clear      = 1'b0;
    cnt_load       = 1'b0;
    cnt_incr       = 1'b0;
    aborted_d      = 1'b0;
    case (state_q)
      IDLE: if (cmd_valid) begin
        load_val_d     = cmd_load_val;
        periods_left_d = cmd_periods;
        state_d        = CLEAR;
      end
      CLEAR: begin
        cnt_clear = 1'b1;
        state_d   = periods_left_q == '0 ? DONE : LOAD;
      end
      LOAD: begin
        cnt_load = 1'b1;
        state_d  = RUN;
      end
      RUN: if (wrap) begin
        cnt_load       = periods_left_q > PER_W'(1);
        periods_left_d = periods_left_q > PER_W'(1) ? periods_left_q - PER_W'(1) : '0;
        state_d        = periods_left_q > PER_W'(1) ? RUN : DONE;
      end else begin
        cnt_incr = tick_en;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (act_abort) begin
      cnt_clear      = 1'b1;
      cnt_load       = 1'b0;
      cnt_incr       = 1'b0;
      state_d        = IDLE;
      periods_left_d = '0;
      aborted_d      = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      periods_left_q <= '0;
      load_val_q     <= '0;
      incr_q         <= 1'b0;
      aborted_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      periods_left_q <= periods_left_d;
      load_val_q     <= load_val_d;
      incr_q         <= cnt_incr;
      aborted_q      <= aborted_d;
    end
  end
  assign cmd_ready    = state_q == IDLE;
  assign busy         = state_q != IDLE;
  assign done         = state_q == DONE && !cmd_abort;
  assign aborted      = aborted_q;
  assign periods_left = periods_left_q;
  assign cnt_d        = load_val_q;
endmodule
